// File: rtl/clkset_pkg.sv
// ============================================================================
// clkset_pkg : set-mode state type and one-hot field decode for clock_set_fsm
// Rev 1.0
// ============================================================================
`default_nettype none

package clkset_pkg;

  localparam int unsigned MAX_FIELDS = 7;
  localparam int unsigned STATE_W    = $clog2(MAX_FIELDS + 1);

  // State index: RUN is 0, SET_k is k. Sized for the largest legal N_FIELDS.
  typedef enum logic [STATE_W-1:0] {
    ST_RUN  = 3'd0,
    ST_SET1 = 3'd1,
    ST_SET2 = 3'd2,
    ST_SET3 = 3'd3,
    ST_SET4 = 3'd4,
    ST_SET5 = 3'd5,
    ST_SET6 = 3'd6,
    ST_SET7 = 3'd7
  } state_t;

  function automatic logic [MAX_FIELDS-1:0] state_onehot(input state_t s);
    logic [MAX_FIELDS-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_FIELDS; i++) begin
      v[i] = (int'(s) == i + 1);
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clkset_btn_edge.sv
// ============================================================================
// clkset_btn_edge : rising-edge detector; previous level resets high so a
// button held through reset must be released first. Rev 1.0
// ============================================================================
`default_nettype none

module clkset_btn_edge
  import clkset_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic edge_o
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_q <= 1'b1;
    end else begin
      btn_q <= btn_i;
    end
  end

  assign edge_o = btn_i & ~btn_q;

endmodule

`default_nettype wire

// File: rtl/clock_set_fsm.sv
// ============================================================================
// clock_set_fsm : clock set-mode controller (field select, inc pulses, blink,
// idle timeout). CLKSET_AUTOREPEAT_EN adds held-button auto-repeat. Rev 1.0
// ============================================================================
`default_nettype none

module clock_set_fsm
  import clkset_pkg::*;
#(
  parameter int unsigned N_FIELDS      = 3,
  parameter int unsigned TIMEOUT_TICKS = 8,
  parameter int unsigned REPEAT_DLY    = 4,
  parameter int unsigned REPEAT_PER    = 2,
  parameter int unsigned BLINK_TICKS   = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick,
  input  logic                            mode_btn,
  input  logic                            inc_btn,
  output logic [N_FIELDS-1:0]             field_sel,
  output logic                            field_inc,
  output logic                            setting,
  output logic [$clog2(N_FIELDS+1)-1:0]   state_idx,
  output logic                            blink
);

  localparam int unsigned IDXW   = $clog2(N_FIELDS + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned BLK_W  = $clog2(BLINK_TICKS + 1);

  localparam logic [IDLE_W-1:0] TIMEOUT_C = IDLE_W'(TIMEOUT_TICKS);
  localparam logic [BLK_W-1:0]  BLINK_C   = BLK_W'(BLINK_TICKS);
  localparam state_t            LAST_C    = state_t'(STATE_W'(N_FIELDS));

  logic mode_edge;
  logic inc_edge;
  logic rpt_pulse;

  state_t              state_q, state_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic                blink_q, blink_d;
  logic                inc_pulse_d;
  logic                field_inc_q;
  logic [N_FIELDS-1:0] field_sel_q;
  logic                setting_q;
  logic [IDXW-1:0]     state_idx_q;

  clkset_btn_edge u_mode_edge (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (mode_btn),
    .edge_o (mode_edge)
  );

  clkset_btn_edge u_inc_edge (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (inc_btn),
    .edge_o (inc_edge)
  );

`ifdef CLKSET_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [RPT_W-1:0] rpt_thresh;
  logic             rpt_armed_q, rpt_armed_d;

  // Counts hold ticks after the press edge; first period is REPEAT_DLY,
  // later ones REPEAT_PER. Release, RUN or a mode edge restarts it.
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_armed_d = 1'b0;
    rpt_pulse   = 1'b0;
    rpt_thresh  = rpt_armed_q ? RPT_W'(REPEAT_PER) : RPT_W'(REPEAT_DLY);
    if (state_q != ST_RUN && inc_btn && !inc_edge && !mode_edge) begin
      rpt_cnt_d   = rpt_cnt_q;
      rpt_armed_d = rpt_armed_q;
      if (tick) begin
        if (rpt_cnt_q + RPT_W'(1) == rpt_thresh) begin
          rpt_pulse   = 1'b1;
          rpt_cnt_d   = '0;
          rpt_armed_d = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
`else
  assign rpt_pulse = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idle_d      = idle_q;
    blk_cnt_d   = blk_cnt_q;
    blink_d     = blink_q;
    inc_pulse_d = 1'b0;
    if (state_q == ST_RUN || mode_edge) begin
      // RUN and every SET entry restart idle and blink timing
      idle_d    = '0;
      blk_cnt_d = '0;
      blink_d   = 1'b1;
      if (mode_edge) begin
        if (state_q == LAST_C) begin
          state_d = ST_RUN;
        end else begin
          state_d = state_t'(state_q + STATE_W'(1));
        end
      end
    end else begin
      if (inc_btn) begin
        idle_d      = '0;
        inc_pulse_d = inc_edge | rpt_pulse;
      end else if (tick) begin
        idle_d = idle_q + IDLE_W'(1);
      end
      if (tick) begin
        if (blk_cnt_q + BLK_W'(1) == BLINK_C) begin
          blk_cnt_d = '0;
          blink_d   = ~blink_q;
        end else begin
          blk_cnt_d = blk_cnt_q + BLK_W'(1);
        end
      end
      if (idle_d == TIMEOUT_C) begin
        state_d   = ST_RUN;
        idle_d    = '0;
        blk_cnt_d = '0;
        blink_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      idle_q      <= '0;
      blk_cnt_q   <= '0;
      blink_q     <= 1'b1;
      field_inc_q <= 1'b0;
      field_sel_q <= '0;
      setting_q   <= 1'b0;
      state_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      blk_cnt_q   <= blk_cnt_d;
      blink_q     <= blink_d;
      field_inc_q <= inc_pulse_d;
      field_sel_q <= N_FIELDS'(state_onehot(state_d));
      setting_q   <= (state_d != ST_RUN);
      state_idx_q <= IDXW'(state_d);
    end
  end

  assign field_sel = field_sel_q;
  assign field_inc = field_inc_q;
  assign setting   = setting_q;
  assign state_idx = state_idx_q;
  assign blink     = blink_q;

endmodule

`default_nettype wire
